// File: rtl/axi_pmu_pkg.sv
// Shared definitions for the PMU CSR slice: register offsets, CTRL bits, counter index order.
// Optional periodic snapshots are enabled with the AXI_PMU_CSR_AUTOSNAP_EN macro.
package axi_pmu_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned NUM_READ_CNT   = 7;
  localparam int unsigned NUM_WRITE_CNT  = 11;

  localparam int unsigned CTRL_OFF       = 32'h000;
  localparam int unsigned STATUS_OFF     = 32'h004;
  localparam int unsigned SNAP_COUNT_OFF = 32'h008;
  localparam int unsigned PERIOD_OFF     = 32'h00C;
  localparam int unsigned SNAP_BASE      = 32'h100;

  localparam int unsigned CTRL_SNAP_BIT  = 0;
  localparam int unsigned CTRL_CLEAR_BIT = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [4:0] {
    CNT_RD_IDLE, CNT_RD_OUTSTANDING, CNT_AR_STALL, CNT_AR_HANDSHAKE,
    CNT_RVALID_STALL, CNT_RREADY_STALL, CNT_R_HANDSHAKE,
    CNT_WR_IDLE, CNT_WR_OUTSTANDING, CNT_WR_RESPONDING, CNT_AW_STALL,
    CNT_AW_HANDSHAKE, CNT_WVALID_STALL, CNT_WREADY_STALL, CNT_W_HANDSHAKE,
    CNT_BVALID_STALL, CNT_BREADY_STALL, CNT_B_HANDSHAKE
  } cnt_idx_e;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_RESP} r_state_e;

  // Word-aligned address falls inside the snapshot window of n 64-bit counters
  function automatic logic is_snap_addr(input logic [31:0] addr, input int unsigned n);
    return (addr >= SNAP_BASE) && (addr < SNAP_BASE + 8 * n);
  endfunction

endpackage

// File: rtl/axi_pmu_snap_bank.sv
// Snapshot register bank: atomic capture of all counters, snapshot count and word-select read mux.
module axi_pmu_snap_bank
  import axi_pmu_pkg::*;
#(
  parameter int unsigned NUM_CNT = 18,
  parameter int unsigned CNT_W   = 64
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_i,
  input  logic                     snap_en,
  input  logic [31:0]              rd_addr,
  output logic [31:0]              rd_data,
  output logic                     rd_hit,
  output logic [31:0]              snap_count,
  output logic                     snap_valid
);

  logic [NUM_CNT*CNT_W-1:0] snap_q;
  logic [31:0]              off;
  logic [63:0]              sel;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      snap_q     <= '0;
      snap_count <= '0;
      snap_valid <= 1'b0;
    end else if (snap_en) begin
      snap_q     <= cnt_i;
      snap_count <= snap_count + 32'd1;
      snap_valid <= 1'b1;
    end
  end

  assign off    = rd_addr - SNAP_BASE;
  assign rd_hit = is_snap_addr(rd_addr, NUM_CNT);

  // Counter select by 8-byte slot, then low/high word by address bit 2
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if ((off >> 3) == 32'(i)) sel = 64'(snap_q[i*CNT_W +: CNT_W]);
    end
    rd_data = '0;
    if (rd_hit) rd_data = off[2] ? sel[63:32] : sel[31:0];
  end

endmodule

// File: rtl/axi_pmu_csr.sv
// AXI4-Lite CSR front end for the PMU: CTRL/STATUS/SNAP_COUNT plus snapshot words.
// Define AXI_PMU_CSR_AUTOSNAP_EN to add the PERIOD register and periodic snapshot timer.
module axi_pmu_csr
  import axi_pmu_pkg::*;
#(
  parameter int unsigned NUM_CNT = 18,
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned ADDR_W  = 12
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_i,
  output logic                     cnt_clear_o,
  input  logic [ADDR_W-1:0]        s_awaddr,
  input  logic                     s_awvalid,
  output logic                     s_awready,
  input  logic [31:0]              s_wdata,
  input  logic [3:0]               s_wstrb,
  input  logic                     s_wvalid,
  output logic                     s_wready,
  output logic [1:0]               s_bresp,
  output logic                     s_bvalid,
  input  logic                     s_bready,
  input  logic [ADDR_W-1:0]        s_araddr,
  input  logic                     s_arvalid,
  output logic                     s_arready,
  output logic [31:0]              s_rdata,
  output logic [1:0]               s_rresp,
  output logic                     s_rvalid,
  input  logic                     s_rready
);

  w_state_e          w_state;
  r_state_e          r_state;
  logic [ADDR_W-1:0] awaddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              aw_hs, w_hs, ar_hs, commit;
  logic [31:0]       wr_addr, wr_data, rd_addr, rd_data_c, bank_rdata, snap_count;
  logic [3:0]        wr_strb;
  logic              is_ctrl, wr_ok, snap_manual, snap_auto, clear_req;
  logic              rd_err_c, bank_hit, snap_valid;
  logic [31:0]       period_rd;

  assign s_awready = aresetn && (w_state == W_IDLE || w_state == W_HAVE_W);
  assign s_wready  = aresetn && (w_state == W_IDLE || w_state == W_HAVE_AW);
  assign s_arready = aresetn && (r_state == R_IDLE);

  assign aw_hs  = s_awvalid && s_awready;
  assign w_hs   = s_wvalid && s_wready;
  assign ar_hs  = s_arvalid && s_arready;
  assign commit = (w_state == W_IDLE && aw_hs && w_hs) ||
                  (w_state == W_HAVE_AW && w_hs) ||
                  (w_state == W_HAVE_W && aw_hs);

  // Commit combines whichever half was latched earlier with the half arriving now
  assign wr_addr = 32'((w_state == W_HAVE_AW) ? awaddr_q : s_awaddr) & ~32'd3;
  assign wr_data = (w_state == W_HAVE_W) ? wdata_q : s_wdata;
  assign wr_strb = (w_state == W_HAVE_W) ? wstrb_q : s_wstrb;

  assign is_ctrl     = wr_addr == CTRL_OFF;
  assign wr_ok       = is_ctrl || wr_addr == STATUS_OFF || wr_addr == SNAP_COUNT_OFF ||
                       wr_addr == PERIOD_OFF || is_snap_addr(wr_addr, NUM_CNT);
  assign snap_manual = commit && is_ctrl && wr_strb[0] && wr_data[CTRL_SNAP_BIT];
  assign clear_req   = commit && is_ctrl && wr_strb[0] && wr_data[CTRL_CLEAR_BIT];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state     <= W_IDLE;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      s_bvalid    <= 1'b0;
      s_bresp     <= RESP_OKAY;
      cnt_clear_o <= 1'b0;
    end else begin
      cnt_clear_o <= clear_req;
      if (commit) begin
        s_bvalid <= 1'b1;
        s_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        w_state  <= W_RESP;
      end else begin
        case (w_state)
          W_IDLE: begin
            if (aw_hs) begin
              awaddr_q <= s_awaddr;
              w_state  <= W_HAVE_AW;
            end else if (w_hs) begin
              wdata_q <= s_wdata;
              wstrb_q <= s_wstrb;
              w_state <= W_HAVE_W;
            end
          end
          W_RESP: begin
            if (s_bready) begin
              s_bvalid <= 1'b0;
              w_state  <= W_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef AXI_PMU_CSR_AUTOSNAP_EN
  logic [31:0] period_q, timer_q;

  // Free-running tick every period_q cycles; any PERIOD write restarts the count
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      period_q <= '0;
      timer_q  <= '0;
    end else if (commit && wr_addr == PERIOD_OFF) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) period_q[8*b +: 8] <= wr_data[8*b +: 8];
      end
      timer_q <= '0;
    end else if (period_q != '0) begin
      timer_q <= snap_auto ? '0 : timer_q + 32'd1;
    end
  end

  assign snap_auto = (period_q != '0) && (timer_q == period_q - 32'd1);
  assign period_rd = period_q;
`else
  logic unused_wr;
  assign unused_wr = ^{wr_data[31:2], wr_strb[3:1]};
  assign snap_auto = 1'b0;
  assign period_rd = '0;
`endif

  axi_pmu_snap_bank #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W)) u_bank (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cnt_i      (cnt_i),
    .snap_en    (snap_manual || snap_auto),
    .rd_addr    (rd_addr),
    .rd_data    (bank_rdata),
    .rd_hit     (bank_hit),
    .snap_count (snap_count),
    .snap_valid (snap_valid)
  );

  assign rd_addr = 32'(s_araddr) & ~32'd3;

  always_comb begin
    rd_data_c = '0;
    rd_err_c  = 1'b0;
    if (rd_addr == CTRL_OFF)            rd_data_c = '0;
    else if (rd_addr == STATUS_OFF)     rd_data_c = {16'h0, 8'(NUM_CNT), 7'h0, snap_valid};
    else if (rd_addr == SNAP_COUNT_OFF) rd_data_c = snap_count;
    else if (rd_addr == PERIOD_OFF)     rd_data_c = period_rd;
    else if (bank_hit)                  rd_data_c = bank_rdata;
    else                                rd_err_c  = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= R_IDLE;
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            s_rdata  <= rd_data_c;
            s_rresp  <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
            s_rvalid <= 1'b1;
            r_state  <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_pmu_csr.sv
// Directed bench for axi_pmu_csr: register map, snapshot/clear ordering, handshake corners, reset.
module tb_axi_pmu_csr;

  localparam int unsigned NUM_CNT = 18;
  localparam int unsigned CNT_W   = 64;

  logic                     aclk = 1'b0;
  logic                     aresetn;
  logic [NUM_CNT*CNT_W-1:0] cnt;
  logic                     cnt_clear_o;
  logic [11:0]              s_awaddr, s_araddr;
  logic                     s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0]              s_wdata, s_rdata;
  logic [3:0]               s_wstrb;
  logic [1:0]               s_bresp, s_rresp;
  logic                     s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axi_pmu_csr #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .ADDR_W(12)) dut (
    .aclk(aclk), .aresetn(aresetn), .cnt_i(cnt), .cnt_clear_o(cnt_clear_o),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; AW and W offered together, bready raised one cycle after bvalid
  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp, input logic exp_clear);
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    chk("wr_awready", 32'(s_awready), 32'd1);
    @(posedge aclk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge aclk);
    chk("wr_bvalid", 32'(s_bvalid), 32'd1);
    chk("wr_bresp", 32'(s_bresp), 32'(exp_resp));
    chk("wr_clear_pulse", 32'(cnt_clear_o), 32'(exp_clear));
    s_bready = 1'b1;
    @(posedge aclk); #1;
    s_bready = 1'b0;
    @(negedge aclk);
    chk("wr_bvalid_drop", 32'(s_bvalid), 32'd0);
    chk("wr_clear_end", 32'(cnt_clear_o), 32'd0);
  endtask

  task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
    s_araddr = addr; s_arvalid = 1'b1;
    chk("rd_arready", 32'(s_arready), 32'd1);
    @(posedge aclk); #1;
    s_arvalid = 1'b0;
    @(negedge aclk);
    chk("rd_rvalid", 32'(s_rvalid), 32'd1);
    data = s_rdata; resp = s_rresp;
    s_rready = 1'b1;
    @(posedge aclk); #1;
    s_rready = 1'b0;
    @(negedge aclk);
    chk("rd_rvalid_drop", 32'(s_rvalid), 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp_data,
                        input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    chk(tag, d, exp_data);
    chk({tag, "_resp"}, 32'(r), 32'(exp_resp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; cnt = '0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst_awready", 32'(s_awready), 32'd0);
    chk("rst_wready", 32'(s_wready), 32'd0);
    chk("rst_arready", 32'(s_arready), 32'd0);
    chk("rst_bvalid", 32'(s_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_clear", 32'(cnt_clear_o), 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    chk("rst_resps", 32'({s_bresp, s_rresp}), 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("idle_wready", 32'(s_wready), 32'd1);
    rd_chk("status_init", 12'h004, 32'h0000_1200, 2'b00);
    rd_chk("count_init", 12'h008, 32'd0, 2'b00);

    // Manual snapshot of counter 3
    cnt[3*CNT_W +: CNT_W] = 64'h0000_0005_0000_0009;
    axi_write(12'h000, 32'h1, 4'hF, 2'b00, 1'b0);
    rd_chk("snap3_lo", 12'h118, 32'h0000_0009, 2'b00);
    rd_chk("snap3_hi", 12'h11C, 32'h0000_0005, 2'b00);
    rd_chk("snap3_lo_unaligned", 12'h11B, 32'h0000_0009, 2'b00);
    rd_chk("count_1", 12'h008, 32'd1, 2'b00);
    rd_chk("status_valid", 12'h004, 32'h0000_1201, 2'b00);
    rd_chk("ctrl_reads_0", 12'h000, 32'd0, 2'b00);

    // SNAP+CLEAR: snapshot keeps the pre-clear value, one clear pulse
    cnt[0 +: CNT_W] = 64'd42;
    axi_write(12'h000, 32'h3, 4'hF, 2'b00, 1'b1);
    cnt[0 +: CNT_W] = 64'd43;
    rd_chk("snap0_lo", 12'h100, 32'd42, 2'b00);
    rd_chk("snap0_hi", 12'h104, 32'd0, 2'b00);
    rd_chk("count_2", 12'h008, 32'd2, 2'b00);

    // W three cycles ahead of AW, bready held off four cycles
    cnt[5*CNT_W +: CNT_W] = 64'h1234_5678_9ABC_DEF0;
    s_wdata = 32'h1; s_wstrb = 4'hF; s_wvalid = 1'b1;
    chk("wfirst_wready", 32'(s_wready), 32'd1);
    @(posedge aclk); #1;
    s_wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      chk("havew_wready", 32'(s_wready), 32'd0);
      chk("havew_awready", 32'(s_awready), 32'd1);
      chk("havew_bvalid", 32'(s_bvalid), 32'd0);
    end
    @(negedge aclk);
    s_awaddr = 12'h000; s_awvalid = 1'b1;
    @(posedge aclk); #1;
    s_awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      chk("bvalid_held", 32'(s_bvalid), 32'd1);
      chk("resp_awready", 32'(s_awready), 32'd0);
    end
    s_bready = 1'b1;
    @(posedge aclk); #1;
    s_bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("no_second_b", 32'(s_bvalid), 32'd0);
    end
    rd_chk("count_3", 12'h008, 32'd3, 2'b00);
    rd_chk("snap5_lo", 12'h128, 32'h9ABC_DEF0, 2'b00);
    rd_chk("snap5_hi", 12'h12C, 32'h1234_5678, 2'b00);
    rd_chk("snap0_after", 12'h100, 32'd43, 2'b00);

    // Decode boundaries and ignored writes
    rd_chk("last_word", 12'h18C, 32'd0, 2'b00);
    rd_chk("past_end", 12'h190, 32'd0, 2'b10);
    rd_chk("bad_read", 12'h200, 32'd0, 2'b10);
    axi_write(12'h000, 32'h3, 4'h0, 2'b00, 1'b0);
    axi_write(12'h300, 32'h1, 4'hF, 2'b10, 1'b0);
    axi_write(12'h004, 32'h1, 4'hF, 2'b00, 1'b0);
    axi_write(12'h118, 32'hFFFF_FFFF, 4'hF, 2'b00, 1'b0);
    rd_chk("count_unchanged", 12'h008, 32'd3, 2'b00);
    rd_chk("snap3_unchanged", 12'h118, 32'h0000_0009, 2'b00);

    // AR handshake in the same cycle as a snapshot load returns the old word
    cnt[1*CNT_W +: CNT_W] = 64'h77;
    s_araddr = 12'h108; s_arvalid = 1'b1;
    s_awaddr = 12'h000; s_wdata = 32'h1; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(posedge aclk); #1;
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge aclk);
    chk("conc_rvalid", 32'(s_rvalid), 32'd1);
    chk("conc_old_data", s_rdata, 32'd0);
    chk("conc_bvalid", 32'(s_bvalid), 32'd1);
    s_rready = 1'b1; s_bready = 1'b1;
    @(posedge aclk); #1;
    s_rready = 1'b0; s_bready = 1'b0;
    @(negedge aclk);
    chk("conc_done", 32'({s_rvalid, s_bvalid}), 32'd0);
    rd_chk("conc_new_data", 12'h108, 32'h77, 2'b00);
    rd_chk("count_4", 12'h008, 32'd4, 2'b00);

    // Reset while a read response is pending
    s_araddr = 12'h118; s_arvalid = 1'b1;
    @(posedge aclk); #1;
    s_arvalid = 1'b0;
    @(negedge aclk);
    chk("pre_rst_rvalid", 32'(s_rvalid), 32'd1);
    chk("pre_rst_rdata", s_rdata, 32'd9);
    aresetn = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(s_rvalid), 32'd0);
    chk("midrst_arready", 32'(s_arready), 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      chk("post_rst_rvalid", 32'(s_rvalid), 32'd0);
    end
    rd_chk("status_after_rst", 12'h004, 32'h0000_1200, 2'b00);
    rd_chk("count_after_rst", 12'h008, 32'd0, 2'b00);
    rd_chk("snap3_after_rst", 12'h118, 32'd0, 2'b00);

`ifdef AXI_PMU_CSR_AUTOSNAP_EN
    // PERIOD=10 for 105 cycles between the two PERIOD commits gives ten auto snapshots
    axi_write(12'h00C, 32'd10, 4'hF, 2'b00, 1'b0);
    repeat (103) @(negedge aclk);
    axi_write(12'h00C, 32'd0, 4'hF, 2'b00, 1'b0);
    rd_chk("auto_count", 12'h008, 32'd10, 2'b00);
    rd_chk("period_off", 12'h00C, 32'd0, 2'b00);
    repeat (50) @(negedge aclk);
    rd_chk("auto_stopped", 12'h008, 32'd10, 2'b00);
`else
    axi_write(12'h00C, 32'd10, 4'hF, 2'b00, 1'b0);
    rd_chk("period_reads_0", 12'h00C, 32'd0, 2'b00);
    repeat (30) @(negedge aclk);
    rd_chk("no_auto_snap", 12'h008, 32'd0, 2'b00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_pmu_csr.md
# axi_pmu_csr

- AXI4-Lite register slave that exposes the AXI performance-monitor counters to software.
- Sits directly downstream of `axi_pmu`: takes its flattened counter vector and captures all counters atomically into a snapshot bank on command.
- Serves the snapshot as 32-bit words and returns a one-cycle clear pulse to the PMU.

## Interface
Parameters:
- NUM_CNT, 18, number of 64-bit counters on cnt_i (7 read + 11 write)
- CNT_W, 64, counter width
- ADDR_W, 12, AXI-Lite address width; data width fixed at 32

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- cnt_i  in  NUM_CNT*CNT_W  live counters, counter i at bits [i*CNT_W +: CNT_W]
- cnt_clear_o  out  1  one-cycle clear pulse to PMU
- s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_W/1/1  write address channel
- s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  32/4/1/1  write data channel
- s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  write response channel
- s_araddr/s_arvalid/s_arready  in/in/out  ADDR_W/1/1  read address channel
- s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  32/2/1/1  read data channel

## Operation
Register map (word-aligned; addr[1:0] ignored):
- 0x000 CTRL, write-only, reads 0.
  - bit0 SNAP: write 1 to capture all cnt_i.
  - bit1 CLEAR: write 1 to pulse cnt_clear_o.
  - Acts only when wstrb[0]=1.
- 0x004 STATUS, read-only: bit0 snap_valid (set by first snapshot, cleared only by reset); [15:8] NUM_CNT.
- 0x008 SNAP_COUNT, read-only: 32-bit count of snapshots taken, wraps 0xFFFFFFFF→0.
- 0x00C PERIOD: see Configuration.
- 0x100+8*i: snapshot i low word. 0x104+8*i: snapshot i high word. Valid for i<NUM_CNT.
- Any other read → SLVERR, rdata 0. Any other write → SLVERR, no effect. Writes to read-only registers → OKAY, ignored.

Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
- AW and W are accepted independently and latched.
- The commit cycle is the cycle in which both are held, including simultaneous acceptance from W_IDLE.
- Commit → W_RESP. bvalid held until bready, then → W_IDLE.

Read FSM states: R_IDLE, R_RESP.
- AR handshake latches rdata/rresp from the snapshot bank and moves to R_RESP.
- rvalid held until rready, then → R_IDLE.

Snapshot and clear ordering:
- At the edge ending the commit cycle, the snapshot bank loads cnt_i, SNAP_COUNT increments and snap_valid sets.
- cnt_clear_o is high exactly one cycle, the cycle after commit.
- SNAP and CLEAR in one write: the snapshot holds pre-clear values.

## Timing
- Reset values:
  - s_awready, s_wready, s_arready, s_bvalid, s_rvalid, cnt_clear_o all 0.
  - bresp, rresp, rdata all 0.
  - Snapshot bank, SNAP_COUNT and snap_valid all 0.
  - Both FSMs idle.
- Readies are decoded from FSM state and forced 0 while aresetn is low.
- s_arready=1 only in R_IDLE.
- s_awready=1 in W_IDLE/W_HAVE_W; s_wready=1 in W_IDLE/W_HAVE_AW.
- Read latency: rvalid one cycle after AR handshake.
- Write latency: bvalid one cycle after commit.
- A read whose AR handshake coincides with a snapshot load returns the old snapshot value.
- Read and write channels operate concurrently without interaction.
- Reset mid-transaction drops the transaction; no response is issued afterwards.

## Configuration
AXI_PMU_CSR_AUTOSNAP_EN defined:
- PERIOD (0x00C, R/W, byte-strobed, reset 0) enables periodic snapshots.
- A 32-bit timer takes a snapshot every PERIOD cycles; PERIOD=0 disables it.
- Any write to PERIOD reloads the timer.
- An auto snapshot coinciding with a manual SNAP counts once.
- cnt_clear_o is never driven by auto snapshots.

Undefined: 0x00C reads 0; writes return OKAY with no effect; no timer logic.

## Structure
- Package `axi_pmu_pkg` holds:
  - Register offsets and CTRL bit indices.
  - NUM_READ_CNT=7, NUM_WRITE_CNT=11.
  - Counter index order:
    - Indices 0–6: idle, outstanding, ar_stall, ar_handshake, rvalid_stall, rready_stall, r_handshake.
    - Indices 7–17: idle, outstanding, responding, aw_stall, aw_handshake, wvalid_stall, wready_stall, w_handshake, bvalid_stall, bready_stall, b_handshake.
- Sub-module `axi_pmu_snap_bank` contains the snapshot registers, SNAP_COUNT and the word-select read mux.

## Test plan
- Counter 3 = 0x0000_0005_0000_0009; write CTRL=0x1; read 0x118/0x11C → 0x00000009/0x00000005 OKAY; SNAP_COUNT reads 1.
- Write CTRL=0x3 with counter 0 = 42 → snapshot 0 reads 42; cnt_clear_o high exactly one cycle, the cycle after commit.
- W presented 3 cycles before AW, bready delayed 4 cycles → single commit; bvalid held 4 cycles; no second write.
- Read 0x200 (NUM_CNT=18) → SLVERR, rdata 0; write CTRL with wstrb=0x0 → OKAY, no snapshot.
- Reset asserted while rvalid=1 → rvalid 0 immediately; after release, STATUS reads 0x1200.
- With AXI_PMU_CSR_AUTOSNAP_EN, PERIOD=10 → SNAP_COUNT=10 after 100 cycles; PERIOD=0 stops the increments.
